// File: rtl/move_scheduler_if.sv
// Key inputs and lane-status outputs of the lane move scheduler.
interface move_scheduler_if;
  logic       left_in;
  logic       right_in;
  logic       pause;
  logic [1:0] curr_pos;
  logic [1:0] prev_pos;
  logic       moving;
  logic       dir;
  logic       step;
  logic [3:0] queue_count;
  logic       overflow;

  modport slave (
    input  left_in, right_in, pause,
    output curr_pos, prev_pos, moving, dir, step, queue_count, overflow
  );

  modport master (
    output left_in, right_in, pause,
    input  curr_pos, prev_pos, moving, dir, step, queue_count, overflow
  );
endinterface

// File: rtl/move_scheduler.sv
// Queues left/right key edges and replays them as timed lane transitions.
// state | meaning
// IDLE  | no transition; pops the queue head when unpaused
// MOVE  | transition in progress; step counter runs down to 0
module move_scheduler #(
  parameter int QDEPTH      = 4,
  parameter int STEP_CYCLES = 8,
  parameter int POS_MAX     = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  move_scheduler_if.slave  sched
);
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef enum logic {IDLE, MOVE} state_t;

  state_t            state_q, state_d;
  logic              left_q, right_q;
  logic [QDEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]        count_q, count_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        curr_q, curr_d, prev_q, prev_d;
  logic              dir_q, dir_d, step_q, step_d, ovf_q, ovf_d;

  logic left_rise, right_rise, push, accept, pop, full, head, legal;

  always_comb begin
    left_rise  = sched.left_in & ~left_q;
    right_rise = sched.right_in & ~right_q;
    // simultaneous left and right edges cancel each other
    push       = left_rise ^ right_rise;
    full       = (count_q == 4'(QDEPTH));
    pop        = (state_q == IDLE) && !sched.pause && (count_q != 4'd0);
    accept     = push && (!full || pop);
    head       = mem_q[rd_ptr_q];
    legal      = head ? (curr_q != 2'(POS_MAX)) : (curr_q != 2'd0);

    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    curr_d   = curr_q;
    prev_d   = prev_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    ovf_d    = ovf_q;

    if (accept) begin
      mem_d[wr_ptr_q] = right_rise;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else if (push) begin
      ovf_d = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + {3'b000, accept} - {3'b000, pop};

    case (state_q)
      IDLE: begin
        // an illegal head is simply consumed by the pop above
        if (pop && legal) begin
          state_d = MOVE;
          dir_d   = head;
          cnt_d   = 8'(STEP_CYCLES - 1);
        end
      end
      MOVE: begin
        if (!sched.pause) begin
          if (cnt_q == 8'd0) begin
            state_d = IDLE;
            prev_d  = curr_q;
            curr_d  = dir_q ? (curr_q + 2'd1) : (curr_q - 2'd1);
            step_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
      cnt_q    <= 8'd0;
      curr_q   <= 2'd0;
      prev_q   <= 2'd0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      left_q   <= sched.left_in;
      right_q  <= sched.right_in;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      curr_q   <= curr_d;
      prev_q   <= prev_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sched.curr_pos    = curr_q;
  assign sched.prev_pos    = prev_q;
  assign sched.moving      = (state_q == MOVE);
  assign sched.dir         = dir_q;
  assign sched.step        = step_q;
  assign sched.queue_count = count_q;
  assign sched.overflow    = ovf_q;
endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter QDEPTH, default 4: move-request queue depth in entries; power of two, 2..8.
REQ-002 Parameter STEP_CYCLES, default 8: cycles one lane transition occupies; range 2..255.
REQ-003 Parameter POS_MAX, default 3: rightmost lane index; lanes are 0..POS_MAX; range 1..3.
REQ-004 Clock  in  1  single clock; all state updates on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-low; low forces reset state immediately.
REQ-006 LeftIn  in  1  debounced, synchronous left-key level.
REQ-007 RightIn  in  1  debounced, synchronous right-key level.
REQ-008 Pause  in  1  high freezes dequeue and any in-progress transition; queue still accepts requests.
REQ-009 CurrPos  out  2  current committed lane.
REQ-010 PrevPos  out  2  lane committed before the most recent move.
REQ-011 Moving  out  1  high while a transition is in progress.
REQ-012 Dir  out  1  direction of current/last transition, 1 = right, 0 = left.
REQ-013 Step  out  1  one-cycle pulse in the first cycle the new CurrPos is visible.
REQ-014 QueueCount  out  4  number of queued requests, 0..QDEPTH.
REQ-015 Overflow  out  1  sticky; a request was dropped because the queue was full.

Function
REQ-016 Edge detect: LeftIn/RightIn SHALL be registered once per cycle; a request is a cycle with input high and registered value low.
REQ-017 Left and right edges in the same cycle SHALL cancel: nothing is enqueued, and Overflow is unchanged.
REQ-018 A single edge SHALL write one 1-bit direction entry into the FIFO on that clock edge; QueueCount reflects it the next cycle.
REQ-019 Queue full with no pop in the same cycle: new request SHALL be dropped and Overflow set to 1.
REQ-020 Queue full with a pop in the same cycle: push SHALL be accepted, QueueCount unchanged, Overflow unchanged.
REQ-021 FSM states: IDLE and MOVE only.
REQ-022 IDLE with QueueCount>0 and Pause=0: the head entry SHALL be popped.
REQ-023 Legal popped entry, meaning the target is within 0..POS_MAX: go to MOVE, set Dir, load the step counter with STEP_CYCLES-1, and assert Moving from the next cycle.
REQ-024 Illegal popped entry (left at lane 0, or right at POS_MAX): the entry SHALL be discarded, the FSM stays in IDLE, and no output other than QueueCount changes; the next entry may be popped the following cycle.
REQ-025 MOVE: the counter SHALL decrement each cycle while Pause=0 and hold while Pause=1.
REQ-026 Exit from MOVE: on the edge where the counter is 0 and Pause=0, CurrPos takes the target, PrevPos takes the old CurrPos, Moving falls, Step pulses, and the FSM returns to IDLE.
REQ-027 Moving SHALL be high for exactly STEP_CYCLES unpaused cycles per move.
REQ-028 Latency: with an empty queue, IDLE and no Pause, the new CurrPos SHALL be visible STEP_CYCLES+2 cycles after the request edge is sampled.
REQ-029 Requests arriving during MOVE SHALL queue and execute in FIFO order; back-to-back moves are separated by exactly one IDLE cycle.
REQ-030 FIFO pointers SHALL wrap modulo QDEPTH; QueueCount never exceeds QDEPTH or underflows.
REQ-031 Dir SHALL hold its last value in IDLE.

Reset
REQ-032 Reset low SHALL asynchronously force CurrPos=0, PrevPos=0, Moving=0, Dir=0, Step=0, QueueCount=0, Overflow=0, both edge registers=0, the counter to 0, and the FSM to IDLE.
REQ-033 Reset mid-MOVE SHALL abandon the transition with no Step pulse; queued entries are lost.
REQ-034 Overflow SHALL clear only on reset.

Verification
REQ-035 Defaults, reset release, single RightIn rising edge at cycle N -> Moving high cycles N+2..N+9; CurrPos 0->1 and Step=1 at N+10; PrevPos=0.
REQ-036 Three right edges 2 cycles apart from lane 0 -> moves execute in order, lanes 1, 2, 3, each separated by one IDLE cycle; a fourth right edge is discarded at POS_MAX with CurrPos staying 3.
REQ-037 Five right edges while the first move is in progress, QDEPTH=4 -> fifth edge dropped, Overflow=1 and remaining 1 until reset; QueueCount peaks at 4.
REQ-038 LeftIn and RightIn rising in the same cycle -> QueueCount unchanged, no move, Overflow=0.
REQ-039 Pause held 5 cycles mid-MOVE -> Moving high for 13 total cycles; CurrPos updates 5 cycles later than in REQ-035.
REQ-040 Reset asserted at the 4th Moving cycle with 2 entries queued -> all outputs return to reset values immediately; no Step pulse; QueueCount=0.
